// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration loader: FSM states and default sizing.
package cgra_cfg_pkg;

  localparam int unsigned DEF_WORD_W     = 32;
  localparam int unsigned DEF_CHAIN_LEN  = 40;
  localparam int unsigned DEF_CLR_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in/serial-out shifter: takes a host word and emits its valid bits LSB first,
// one per enabled cycle, on registered bit/shift outputs.
module cfg_piso
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic                         load_i,
  input  logic [WORD_W-1:0]            data_i,
  input  logic [$clog2(WORD_W+1)-1:0]  nbits_i,
  output logic                         bit_o,
  output logic                         shift_o,
  output logic                         shift_next_c_o,
  output logic                         empty_next_c_o
);

  localparam int unsigned WCNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              bit_q, bit_d;
  logic              shift_q, shift_d;

  // cnt_q counts bits still waiting in sreg_q; a new word is only taken once it is zero,
  // so the word's bit 0 goes out in the cycle right after it is accepted.
  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = 1'b0;
    if (clr_i) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (en_i) begin
      if (cnt_q != '0) begin
        bit_d   = sreg_q[0];
        shift_d = 1'b1;
        sreg_d  = sreg_q >> 1;
        cnt_d   = cnt_q - WCNT_W'(1);
      end else if (load_i && (nbits_i != '0)) begin
        bit_d   = data_i[0];
        shift_d = 1'b1;
        sreg_d  = data_i >> 1;
        cnt_d   = nbits_i - WCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign bit_o          = bit_q;
  assign shift_o        = shift_q;
  assign shift_next_c_o = shift_d;
  assign empty_next_c_o = (cnt_d == '0);

endmodule

// File: rtl/config_loader.sv
// Streams a host bitstream into a serial PE configuration chain: clear phase, then
// exactly CHAIN_LEN shifted bits, then a one-cycle done pulse.
module config_loader
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int unsigned CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              cfg_bit,
  output logic              cfg_shift,
  output logic              cfg_reset,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BCNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCNT_W = $clog2(WORD_W + 1);
  localparam int unsigned CLR_W  = $clog2(CLR_CYCLES + 1);

  localparam logic [BCNT_W-1:0] CHAIN_BITS = BCNT_W'(CHAIN_LEN);
  localparam logic [CLR_W-1:0]  CLR_LAST   = CLR_W'(CLR_CYCLES - 1);

  cfg_state_e        state_q, state_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              cfg_reset_q, cfg_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              piso_clr;
  logic              piso_en;
  logic              piso_load;
  logic              piso_shift_next;
  logic              piso_empty_next;
  logic [BCNT_W-1:0] rem_bits;
  logic [WCNT_W-1:0] word_bits;

  // FSM next state and phase control
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    piso_clr  = 1'b0;
    piso_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          piso_clr  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_LOAD;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      ST_LOAD: begin
        if (bit_cnt_q == CHAIN_BITS) begin
          state_d = ST_DONE;
        end else begin
          piso_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The final word is trimmed to whatever is left of the chain.
  always_comb begin
    rem_bits = CHAIN_BITS - bit_cnt_q;
    if (32'(rem_bits) >= WORD_W) begin
      word_bits = WCNT_W'(WORD_W);
    end else begin
      word_bits = WCNT_W'(rem_bits);
    end
  end

  assign piso_load = s_valid & s_ready_q;

  // Bit counter and next values of the registered outputs
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (piso_clr) begin
      bit_cnt_d = '0;
    end else if (piso_shift_next) begin
      bit_cnt_d = bit_cnt_q + BCNT_W'(1);
    end
    s_ready_d   = (state_d == ST_LOAD) && piso_empty_next && (bit_cnt_d != CHAIN_BITS);
    cfg_reset_d = (state_d == ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      cfg_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      s_ready_q   <= s_ready_d;
      cfg_reset_q <= cfg_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk_i          (clk),
    .reset_i        (reset),
    .clr_i          (piso_clr),
    .en_i           (piso_en),
    .load_i         (piso_load),
    .data_i         (s_data),
    .nbits_i        (word_bits),
    .bit_o          (cfg_bit),
    .shift_o        (cfg_shift),
    .shift_next_c_o (piso_shift_next),
    .empty_next_c_o (piso_empty_next)
  );

  assign s_ready   = s_ready_q;
  assign cfg_reset = cfg_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: expected chain bits are queued on word acceptance
// and popped on every cfg_shift cycle; a 40-element chain model checks the final content.
module tb_config_loader;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CHAIN_LEN  = 40;
  localparam int unsigned CLR_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;
  logic              cfg_bit;
  logic              cfg_shift;
  logic              cfg_reset;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit                   exp_q[$];
  logic [CHAIN_LEN-1:0] chain;
  int  shifts, gaps, clr_cycles, dones, ready_after;
  int  first_shift_cyc, last_shift_cyc, done_cyc, acc0_cyc;
  bit  last_bit, watch_ready;

  config_loader #(
    .WORD_W     (WORD_W),
    .CHAIN_LEN  (CHAIN_LEN),
    .CLR_CYCLES (CLR_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .cfg_bit   (cfg_bit),
    .cfg_shift (cfg_shift),
    .cfg_reset (cfg_reset),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mon_clear();
    exp_q.delete();
    chain           = '0;
    shifts          = 0;
    gaps            = 0;
    clr_cycles      = 0;
    dones           = 0;
    ready_after     = 0;
    first_shift_cyc = -1;
    last_shift_cyc  = -1;
    done_cyc        = -1;
    acc0_cyc        = -1;
    last_bit        = 1'b0;
    watch_ready     = 1'b0;
  endtask

  // Advance to the next falling edge and observe the cycle's outputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cfg_shift) begin
      check("shift_rst_excl", 64'(cfg_reset), 64'(0));
      if (exp_q.size() == 0) begin
        check("extra_shift", 64'(cfg_shift), 64'(0));
      end else begin
        last_bit = exp_q.pop_front();
        check("cfg_bit", 64'(cfg_bit), 64'(last_bit));
      end
      chain = {cfg_bit, chain[CHAIN_LEN-1:1]};
      shifts++;
      if (first_shift_cyc < 0) first_shift_cyc = cyc;
      last_shift_cyc = cyc;
    end else if (shifts > 0 && shifts < int'(CHAIN_LEN)) begin
      gaps++;
      check("gap_hold", 64'(cfg_bit), 64'(last_bit));
    end
    if (cfg_reset) begin
      clr_cycles++;
      check("clr_ready", 64'(s_ready), 64'(0));
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (watch_ready && s_ready) ready_after++;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int idx);
    int n;
    bit acc;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    for (int k = 0; k < 200; k++) begin
      if (s_ready) begin
        acc = 1'b1;
        break;
      end
      tick();
    end
    if (!acc) begin
      check("ready_timeout", 64'(s_ready), 64'(1));
    end else begin
      if (idx == 0) acc0_cyc = cyc;
      n = int'(CHAIN_LEN) - idx * int'(WORD_W);
      if (n > int'(WORD_W)) n = int'(WORD_W);
      for (int b = 0; b < n; b++) exp_q.push_back(w[b]);
      if (idx == 1) watch_ready = 1'b1;
    end
    tick();
  endtask

  task automatic run_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                          input int gap, input bit poke, input string tag);
    logic [2*WORD_W-1:0]  full;
    logic [CHAIN_LEN-1:0] exp_chain;
    int k;
    full      = {w1, w0};
    exp_chain = full[CHAIN_LEN-1:0];
    mon_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(w0, 0);
    if (poke) begin
      s_valid = 1'b1;
      s_data  = w1;
      start   = 1'b1;
      tick();
      start   = 1'b0;
    end
    if (gap > 0) begin
      s_valid = 1'b0;
      k = 0;
      while (!s_ready && k < 200) begin
        tick();
        k++;
      end
      if (!s_ready) check({tag, "_gap_ready"}, 64'(s_ready), 64'(1));
      repeat (gap) tick();
    end
    send_word(w1, 1);
    // Offer a surplus word; it must never be consumed.
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    k = 0;
    while (dones == 0 && k < 200) begin
      tick();
      k++;
    end
    s_valid = 1'b0;
    check({tag, "_done_seen"}, 64'(dones), 64'(1));
    check({tag, "_clr_cycles"}, 64'(clr_cycles), 64'(CLR_CYCLES));
    check({tag, "_shifts"}, 64'(shifts), 64'(CHAIN_LEN));
    check({tag, "_gaps"}, 64'(gaps), 64'(gap));
    check({tag, "_exp_left"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_chain"}, 64'(chain), 64'(exp_chain));
    check({tag, "_first_lat"}, 64'(first_shift_cyc), 64'(acc0_cyc + 1));
    check({tag, "_done_lat"}, 64'(done_cyc), 64'(last_shift_cyc + 1));
    check({tag, "_ready_after"}, 64'(ready_after), 64'(0));
    tick();
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check({tag, "_idle_done"}, 64'(done), 64'(0));
    check({tag, "_single_done"}, 64'(dones), 64'(1));
  endtask

  initial begin
    int k;
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    mon_clear();
    tick();
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_cfg_bit", 64'(cfg_bit), 64'(0));
    check("rst_cfg_shift", 64'(cfg_shift), 64'(0));
    check("rst_cfg_reset", 64'(cfg_reset), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    tick();
    reset = 1'b0;
    tick();

    run_load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 1'b0, "cont");
    run_load(32'hA5A5_0F0F, 32'h0000_00C3, 5, 1'b0, "gap5");
    run_load(32'hA5A5_0F0F, 32'hFFFF_FFC3, 0, 1'b1, "trim");

    // Abort mid-load with reset after 20 shifts.
    mon_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'hA5A5_0F0F, 0);
    k = 0;
    while (shifts < 20 && k < 200) begin
      tick();
      k++;
    end
    check("abort_shifts", 64'(shifts), 64'(20));
    reset   = 1'b1;
    s_valid = 1'b0;
    mon_clear();
    tick();
    reset = 1'b0;
    check("abort_s_ready", 64'(s_ready), 64'(0));
    check("abort_cfg_bit", 64'(cfg_bit), 64'(0));
    check("abort_cfg_shift", 64'(cfg_shift), 64'(0));
    check("abort_cfg_reset", 64'(cfg_reset), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    repeat (5) tick();
    check("abort_no_done", 64'(dones), 64'(0));
    check("abort_no_shift", 64'(shifts), 64'(0));
    run_load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 1'b0, "reload");

    // start together with reset is ignored.
    mon_clear();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rs_busy", 64'(busy), 64'(0));
    repeat (6) tick();
    check("rs_no_clear", 64'(clr_cycles), 64'(0));
    check("rs_still_idle", 64'(busy), 64'(0));
    run_load(32'h1234_5678, 32'h0000_009A, 0, 1'b0, "after_rs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
